window_line_buffer: RTL
=======================

# window_line_buffer

Parametrised line-window buffer for the filter datapath. It collects one line segment of pixels from the Avalon master read stream and keeps the most recent WIN lines. Once WIN lines are resident, it slides a WIN×WIN pixel window across them under a valid/ready handshake. It sits between the master read interface and the filter/pixel-processing stage, and generalises the fixed 3×3, 24-bit, 8-pixel line buffer to arbitrary pixel width, window size and line length. It adds backpressure, frame restart and overrun detection.

## Interface
- PIXEL_W, default 24: bits per pixel; taken from master_readdata[PIXEL_W-1:0]; legal range 1..32.
- WIN, default 3: window edge, in both rows and columns; legal range ≥2.
- LINE_PIX, default 8: pixels per line segment; must be ≥ WIN.
- clk  in  1  system clock; all state changes on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- load_start  in  1  request to load the next line; honoured only in IDLE.
- clear_rows  in  1  new frame; honoured only in IDLE; empties resident rows.
- master_readdata  in  32  Avalon read data.
- master_readdatavalid  in  1  read data beat valid.
- window_ready  in  1  consumer accepts the current window.
- window_data  out  WIN*WIN*PIXEL_W  current window.
- window_valid  out  1  window_data is valid.
- window_last  out  1  the current window is the last one of the line.
- done_load  out  1  one-cycle pulse: line load finished.
- busy  out  1  state ≠ IDLE.
- overrun  out  1  sticky: readdatavalid arrived outside LOAD.

## Operation
- Storage:
  - staging register of LINE_PIX pixels;
  - rows row[0..WIN-1], each LINE_PIX pixels; row[0] is the newest line;
  - rows_filled counter, saturating at WIN;
  - beat counter 0..LINE_PIX-1;
  - column counter col 0..LINE_PIX-WIN.
- IDLE:
  - clear_rows → rows_filled=0. Row contents are not cleared.
  - Otherwise, load_start → LOAD with beat=0.
  - If both are high, clear_rows is applied and load_start is also taken (the clear precedes the load).
- LOAD:
  - Each master_readdatavalid beat writes staging[beat] and increments beat.
  - On the beat where beat==LINE_PIX-1, the following happen at the same edge:
    - row[k]←row[k-1] for k=WIN-1..1, and row[0]←staging, where staging already includes the final pixel;
    - rows_filled increments (saturating);
    - done_load is pulsed;
    - beat=0.
  - Next state is SLIDE with col=0 if the new rows_filled==WIN, else IDLE.
  - load_start and clear_rows are ignored in LOAD.
- SLIDE:
  - window_valid=1.
  - On window_valid&&window_ready:
    - if col==LINE_PIX-WIN → IDLE, col=0;
    - else col+1.
  - Windows per line = LINE_PIX-WIN+1. Defaults give 6.
- window_data packing: the pixel from row r, column col+k sits at bits [((r*WIN)+k)*PIXEL_W +: PIXEL_W]. r=0 is the newest row and k=0 is the leftmost pixel, so the LSBs hold the newest row's leftmost pixel.
  - window_data is driven from the rows in every state.
  - It is only meaningful while window_valid=1.
- window_last = window_valid && col==LINE_PIX-WIN.
- overrun:
  - set by master_readdatavalid in IDLE or SLIDE; that data is dropped;
  - cleared only by reset.
- Reset values, applying to any state including mid-LOAD or mid-SLIDE:
  - state=IDLE, rows_filled=0, beat=0, col=0;
  - all outputs 0, including window_data;
  - staging and rows cleared to 0.

## Timing
- Load latency: if the last beat is accepted at edge N, then in the cycle after edge N:
  - done_load=1 for exactly that one cycle;
  - busy=1 if entering SLIDE, else busy=0;
  - window_valid=1 when entering SLIDE.
- Beats may be non-contiguous. The beat counter holds across gaps.
- window_data is stable while window_valid=1 and window_ready=0.
- With window_ready held at 1, SLIDE lasts exactly LINE_PIX-WIN+1 cycles, then busy falls.
- load_start is sampled only in IDLE. A request that arrives during LOAD or SLIDE is lost and must be held or reissued by the requester.
- A new line while WIN rows are resident evicts row[WIN-1]: steady-state sliding-window operation.

## Test plan
- Reset: hold n_rst=0 mid-LOAD, with beats 0..3 already accepted. Required response:
  - all outputs 0;
  - after release, an 8-beat load gives done_load and rows_filled=1, with no window.
- Fill, defaults: load lines with pixel values L*16+p for lines L=1,2,3 and p=0..7. Required response:
  - no window_valid after lines 1 and 2;
  - after line 3, 6 windows;
  - the first window has LSB pixel 0x30, the row-2 leftmost pixel 0x10, and the top word 0x12;
  - window_last is high on the 6th window only.
- Backpressure: window_ready=0 for 5 cycles on window 2. Required response:
  - window_data and col are unchanged;
  - 6 windows total, none duplicated.
- Gapped beats: insert readdatavalid=0 gaps between every beat. Required response: identical rows and a single done_load.
- Overrun: readdatavalid in IDLE with data 0xABCDEF. Required response:
  - overrun=1 and sticky;
  - the next load is unaffected by 0xABCDEF.
- Frame restart: clear_rows after 3 lines, then load 2 lines. Required response: no window_valid; the 3rd line produces windows again.

Source files
------------

// File: rtl/window_line_buffer.sv
// Sliding WIN x WIN pixel window over the most recent WIN line segments
// loaded from an Avalon read stream, with backpressure, frame restart and overrun flag.
module window_line_buffer #(
    parameter int PIXEL_W  = 24,
    parameter int WIN      = 3,
    parameter int LINE_PIX = 8
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         load_start,
    input  logic                         clear_rows,
    input  logic [31:0]                  master_readdata,
    input  logic                         master_readdatavalid,
    input  logic                         window_ready,
    output logic [WIN*WIN*PIXEL_W-1:0]   window_data,
    output logic                         window_valid,
    output logic                         window_last,
    output logic                         done_load,
    output logic                         busy,
    output logic                         overrun
);

    localparam int BW = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
    localparam int FW = $clog2(WIN + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_PIX - 1);
    localparam logic [BW-1:0] COL_LAST  = BW'(LINE_PIX - WIN);
    localparam logic [FW-1:0] FILL_FULL = FW'(WIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SLIDE
    } state_t;

    state_t                                      state_q, state_d;
    logic [LINE_PIX-1:0][PIXEL_W-1:0]            staging_q, staging_d;
    logic [WIN-1:0][LINE_PIX-1:0][PIXEL_W-1:0]   rows_q, rows_d;
    logic [FW-1:0]                               fill_q, fill_d;
    logic [BW-1:0]                               beat_q, beat_d;
    logic [BW-1:0]                               col_q, col_d;
    logic                                        done_q, done_d;
    logic                                        overrun_q, overrun_d;
    logic [FW-1:0]                               fill_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            staging_q <= '0;
            rows_q    <= '0;
            fill_q    <= '0;
            beat_q    <= '0;
            col_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            staging_q <= staging_d;
            rows_q    <= rows_d;
            fill_q    <= fill_d;
            beat_q    <= beat_d;
            col_q     <= col_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        rows_d    = rows_q;
        fill_d    = fill_q;
        beat_d    = beat_q;
        col_d     = col_q;
        done_d    = 1'b0;
        fill_next = fill_q;
        // Beats outside LOAD are dropped but remembered.
        overrun_d = overrun_q | (master_readdatavalid && (state_q != S_LOAD));

        case (state_q)
            S_IDLE: begin
                if (clear_rows) begin
                    fill_d = '0;
                end
                if (load_start) begin
                    state_d = S_LOAD;
                    beat_d  = '0;
                end
            end
            S_LOAD: begin
                if (master_readdatavalid) begin
                    staging_d[beat_q] = master_readdata[PIXEL_W-1:0];
                    if (beat_q == BEAT_LAST) begin
                        // staging_d already holds the final pixel, so the new row is complete.
                        for (int unsigned k = WIN - 1; k > 0; k--) begin
                            rows_d[k] = rows_q[k-1];
                        end
                        rows_d[0] = staging_d;
                        fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
                        fill_d    = fill_next;
                        done_d    = 1'b1;
                        beat_d    = '0;
                        col_d     = '0;
                        state_d   = (fill_next == FILL_FULL) ? S_SLIDE : S_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_SLIDE: begin
                if (window_ready) begin
                    if (col_q == COL_LAST) begin
                        state_d = S_IDLE;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logic [BW-1:0] idx;
        window_data = '0;
        idx         = '0;
        for (int unsigned r = 0; r < WIN; r++) begin
            for (int unsigned k = 0; k < WIN; k++) begin
                idx = col_q + BW'(k);
                window_data[((r*WIN)+k)*PIXEL_W +: PIXEL_W] = rows_q[r][idx];
            end
        end
    end

    assign window_valid = (state_q == S_SLIDE);
    assign window_last  = window_valid && (col_q == COL_LAST);
    assign busy         = (state_q != S_IDLE);
    assign done_load    = done_q;
    assign overrun      = overrun_q;

endmodule
